// File: rtl/gstmcu_pkg.sv
// Shared gstmcu definitions: slot-owner grant bit indices, DRAM phase encoding
// and the per-phase RAS/CAS strobe table.
package gstmcu_pkg;

    localparam int unsigned GRANT_W = 4;
    localparam int unsigned GNT_REF = 0;
    localparam int unsigned GNT_VID = 1;
    localparam int unsigned GNT_DMA = 2;
    localparam int unsigned GNT_CPU = 3;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned PEND_W  = 3;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    typedef struct packed {
        logic xras;
        logic xcas;
    } strobe_t;

    // Refresh uses CAS-before-RAS; every other owner does a normal RAS-then-CAS access.
    function automatic strobe_t slot_strobes(input phase_t ph, input logic [GRANT_W-1:0] gnt);
        strobe_t s;
        s.xras = 1'b1;
        s.xcas = 1'b1;
        if (gnt[GNT_REF]) begin
            s.xcas = (ph != P1);
            s.xras = !((ph == P2) || (ph == P3));
        end else if (gnt != '0) begin
            s.xras = (ph == P0);
            s.xcas = !((ph == P2) || (ph == P3));
        end
        return s;
    endfunction

endpackage

// File: rtl/dram_slot_sched_refresh_timer.sv
// Refresh timing: slot divider raising refresh requests and a saturating
// pending-refresh count; ref_due_c reports whether a refresh is owed after this edge.
module refresh_timer
    import gstmcu_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 64,
    parameter int unsigned REFRESH_MAX = 3
) (
    input  logic c,
    input  logic xr,
    input  logic slot_end,
    input  logic ref_done,
    output logic ref_due_c
);

    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_nxt;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_nxt;
    logic              tick;

    always_ff @(posedge c or negedge xr) begin
        if (!xr) begin
            div_q  <= '0;
            pend_q <= '0;
        end else begin
            div_q  <= div_nxt;
            pend_q <= pend_nxt;
        end
    end

    // A tick and a completion on the same edge cancel out.
    always_comb begin
        tick     = slot_end && (div_q == DIV_W'(REFRESH_DIV - 1));
        div_nxt  = div_q;
        pend_nxt = pend_q;
        if (slot_end) begin
            div_nxt = tick ? '0 : div_q + DIV_W'(1);
        end
        if (tick && !ref_done && (pend_q != PEND_W'(REFRESH_MAX))) begin
            pend_nxt = pend_q + PEND_W'(1);
        end else if (ref_done && !tick && (pend_q != '0)) begin
            pend_nxt = pend_q - PEND_W'(1);
        end
        ref_due_c = (pend_nxt != '0);
    end

endmodule

// File: rtl/dram_slot_sched.sv
// DRAM slot scheduler: four-phase slots shared between refresh, video, DMA and CPU,
// with RAS/CAS strobe generation and per-owner completion pulses.
module dram_slot_sched
    import gstmcu_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 64,
    parameter int unsigned REFRESH_MAX = 3
) (
    input  logic               c,
    input  logic               xr,
    input  logic               cyc_en,
    input  logic               vid_req,
    input  logic               vid_sync,
    input  logic               dma_req,
    input  logic               cpu_req,
    output logic [GRANT_W-1:0] grant,
    output logic               xras,
    output logic               xcas,
    output logic               vid_ld,
    output logic               vid_inc,
    output logic               dma_ack,
    output logic               cpu_ack,
    output logic               ref_inc
);

    phase_t             phase_q, phase_nxt;
    logic               armed_q, armed_nxt;
    logic               parity_q, parity_nxt;
    logic               sync_q, sync_nxt;
    logic               skip_q, skip_nxt;
    logic [GRANT_W-1:0] grant_nxt;
    logic               vid_ld_nxt, vid_inc_nxt, dma_ack_nxt, cpu_ack_nxt, ref_inc_nxt;
    strobe_t            strb;

    logic wrap_c, start_c, load_c, ref_done_c, ref_due_c;

    refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .REFRESH_MAX (REFRESH_MAX)
    ) u_refresh (
        .c         (c),
        .xr        (xr),
        .slot_end  (wrap_c),
        .ref_done  (ref_done_c),
        .ref_due_c (ref_due_c)
    );

    // armed_q is clear until the first enabled edge after reset, which starts slot 0.
    always_comb begin
        wrap_c     = cyc_en && armed_q && (phase_q == P3);
        start_c    = cyc_en && !armed_q;
        load_c     = vid_sync && !sync_q;
        ref_done_c = wrap_c && grant[GNT_REF];
    end

    always_ff @(posedge c or negedge xr) begin
        if (!xr) begin
            phase_q  <= P0;
            armed_q  <= 1'b0;
            parity_q <= 1'b0;
            sync_q   <= 1'b0;
            skip_q   <= 1'b0;
            grant    <= '0;
            xras     <= 1'b1;
            xcas     <= 1'b1;
            vid_ld   <= 1'b0;
            vid_inc  <= 1'b0;
            dma_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            ref_inc  <= 1'b0;
        end else begin
            phase_q  <= phase_nxt;
            armed_q  <= armed_nxt;
            parity_q <= parity_nxt;
            sync_q   <= sync_nxt;
            skip_q   <= skip_nxt;
            grant    <= grant_nxt;
            xras     <= strb.xras;
            xcas     <= strb.xcas;
            vid_ld   <= vid_ld_nxt;
            vid_inc  <= vid_inc_nxt;
            dma_ack  <= dma_ack_nxt;
            cpu_ack  <= cpu_ack_nxt;
            ref_inc  <= ref_inc_nxt;
        end
    end

    always_comb begin
        phase_nxt   = phase_q;
        armed_nxt   = armed_q || cyc_en;
        parity_nxt  = parity_q;
        sync_nxt    = vid_sync;
        skip_nxt    = skip_q;
        grant_nxt   = grant;
        vid_ld_nxt  = load_c;
        vid_inc_nxt = 1'b0;
        dma_ack_nxt = 1'b0;
        cpu_ack_nxt = 1'b0;
        ref_inc_nxt = 1'b0;

        if (cyc_en && armed_q) begin
            case (phase_q)
                P0:      phase_nxt = P1;
                P1:      phase_nxt = P2;
                P2:      phase_nxt = P3;
                default: phase_nxt = P0;
            endcase
        end

        // A video load cancels the increment due now and the one at the next slot end.
        if (wrap_c) begin
            parity_nxt  = !parity_q;
            vid_inc_nxt = grant[GNT_VID] && !(load_c || skip_q);
            dma_ack_nxt = grant[GNT_DMA];
            cpu_ack_nxt = grant[GNT_CPU];
            ref_inc_nxt = grant[GNT_REF];
            skip_nxt    = 1'b0;
        end
        if (load_c) begin
            skip_nxt = 1'b1;
        end

        if (wrap_c || start_c) begin
            grant_nxt = '0;
            if (ref_due_c) begin
                grant_nxt[GNT_REF] = 1'b1;
            end else if (vid_req && !parity_nxt) begin
                grant_nxt[GNT_VID] = 1'b1;
            end else if (dma_req) begin
                grant_nxt[GNT_DMA] = 1'b1;
            end else if (cpu_req) begin
                grant_nxt[GNT_CPU] = 1'b1;
            end
        end

        strb = slot_strobes(phase_nxt, grant_nxt);
    end

endmodule

// File: tb/tb_dram_slot_sched.sv
// Randomized bench for dram_slot_sched against a slot-level behavioural model,
// plus a standalone refresh_timer instance for pending-count saturation.
module tb_dram_slot_sched;

    localparam int DIV    = 4;
    localparam int MAX    = 3;
    localparam int RT_DIV = 8;

    logic c = 1'b0;
    logic xr = 1'b0;
    logic cyc_en = 1'b0, vid_req = 1'b0, vid_sync = 1'b0, dma_req = 1'b0, cpu_req = 1'b0;
    logic [3:0] grant;
    logic xras, xcas, vid_ld, vid_inc, dma_ack, cpu_ack, ref_inc;
    logic rt_slot_end = 1'b0, rt_ref_done = 1'b0, rt_due;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0..3, slot index (parity = slot % 2), owner -1 idle / 0 ref / 1 vid / 2 dma / 3 cpu
    int m_phase, m_slot, m_owner, m_wraps, m_pend;
    bit m_started, m_sync_prev, m_load_since;
    bit e_vid_ld, e_vid_inc, e_dma_ack, e_cpu_ack, e_ref_inc;

    always #5 c = ~c;

    dram_slot_sched #(.REFRESH_DIV(DIV), .REFRESH_MAX(MAX)) dut (
        .c(c), .xr(xr), .cyc_en(cyc_en), .vid_req(vid_req), .vid_sync(vid_sync),
        .dma_req(dma_req), .cpu_req(cpu_req), .grant(grant), .xras(xras), .xcas(xcas),
        .vid_ld(vid_ld), .vid_inc(vid_inc), .dma_ack(dma_ack), .cpu_ack(cpu_ack), .ref_inc(ref_inc)
    );

    refresh_timer #(.REFRESH_DIV(RT_DIV), .REFRESH_MAX(MAX)) u_rt (
        .c(c), .xr(xr), .slot_end(rt_slot_end), .ref_done(rt_ref_done), .ref_due_c(rt_due)
    );

    function automatic void model_reset();
        m_phase = 0; m_slot = 0; m_owner = -1; m_wraps = 0; m_pend = 0;
        m_started = 0; m_sync_prev = 0; m_load_since = 0;
        e_vid_ld = 0; e_vid_inc = 0; e_dma_ack = 0; e_cpu_ack = 0; e_ref_inc = 0;
    endfunction

    function automatic void model_edge();
        bit load, wrap, start;
        load  = vid_sync && !m_sync_prev;
        m_sync_prev = vid_sync;
        wrap  = cyc_en && m_started && (m_phase == 3);
        start = cyc_en && !m_started;
        e_vid_ld = load; e_vid_inc = 0; e_dma_ack = 0; e_cpu_ack = 0; e_ref_inc = 0;
        if (wrap) begin
            case (m_owner)
                0: e_ref_inc = 1;
                1: e_vid_inc = !(load || m_load_since);
                2: e_dma_ack = 1;
                3: e_cpu_ack = 1;
                default: ;
            endcase
            m_wraps++;
            m_pend = m_pend + int'(m_wraps % DIV == 0) - int'(m_owner == 0);
            if (m_pend > MAX) m_pend = MAX;
            m_slot++;
            m_load_since = load;
        end else if (load) begin
            m_load_since = 1;
        end
        if (wrap || start) begin
            if (m_pend > 0)                        m_owner = 0;
            else if (vid_req && (m_slot % 2 == 0)) m_owner = 1;
            else if (dma_req)                      m_owner = 2;
            else if (cpu_req)                      m_owner = 3;
            else                                   m_owner = -1;
        end
        if (cyc_en && m_started) m_phase = (m_phase + 1) % 4;
        if (start) m_started = 1;
    endfunction

    function automatic logic [10:0] model_vec();
        logic [3:0] g;
        logic ras, cas;
        g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        ras = 1; cas = 1;
        if (m_owner == 0) begin
            cas = !(m_phase == 1);
            ras = !(m_phase >= 2);
        end else if (m_owner > 0) begin
            ras = !(m_phase >= 1);
            cas = !(m_phase >= 2);
        end
        return {g, ras, cas, e_vid_ld, e_vid_inc, e_dma_ack, e_cpu_ack, e_ref_inc};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {grant, xras, xcas, vid_ld, vid_inc, dma_ack, cpu_ack, ref_inc};
    endfunction

    task automatic cycle();
        @(posedge c);
        if (xr) model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cyc_en = 1'($urandom); dma_req = 1'($urandom); cpu_req = 1'($urandom);
            vid_req = 1'($urandom);
            @(posedge c); #1;
            n_tests++;
            if (dut_vec() !== 11'b0000_11_00000) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d got=%b exp=%b", i, dut_vec(), 11'b0000_11_00000);
            end
        end
        cyc_en = 0; vid_req = 0; dma_req = 0; cpu_req = 0;
        @(negedge c); xr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_cpu_only();
        int acks = 0, exp_acks = 0;
        cyc_en = 1; cpu_req = 1;
        for (int i = 0; i < 48; i++) begin
            cycle();
            acks += int'(cpu_ack); exp_acks += int'(e_cpu_ack);
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL cpu_only cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
            end
        end
        n_tests++;
        if (acks !== exp_acks || exp_acks < 8) begin
            n_fail++;
            $display("FAIL cpu_ack_count got=%0d exp=%0d", acks, exp_acks);
        end
    endtask

    task automatic test_vid_cpu();
        cyc_en = 1; vid_req = 1; cpu_req = 1; dma_req = 0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL vid_cpu cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_refresh();
        bit cas_seen = 0;
        int refs = 0;
        cyc_en = 1; vid_req = 1; dma_req = 1; cpu_req = 1;
        for (int i = 0; i < 96; i++) begin
            cycle();
            refs += int'(ref_inc);
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL refresh cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
            end
            if (grant !== 4'b0001) cas_seen = 0;
            else if (!xcas) cas_seen = 1;
            if (grant === 4'b0001 && !xras) begin
                n_tests++;
                if (!cas_seen) begin
                    n_fail++;
                    $display("FAIL cbr_order cyc=%0d got=ras_before_cas exp=cas_first", i);
                end
            end
        end
        n_tests++;
        if (refs < 5) begin
            n_fail++;
            $display("FAIL ref_inc_count got=%0d exp>=5", refs);
        end
    endtask

    task automatic test_sync_collision();
        bit hit = 0;
        cyc_en = 1; vid_req = 1; dma_req = 0; cpu_req = 0; vid_sync = 0;
        cycle();
        for (int i = 0; i < 64 && !hit; i++) begin
            vid_sync = (m_phase == 3 && m_owner == 1 && !m_load_since && !m_sync_prev);
            hit = vid_sync;
            cycle();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL sync_walk cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
            end
        end
        n_tests++;
        if (!hit || vid_ld !== 1'b1 || vid_inc !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_collision hit=%0d got ld=%b inc=%b exp ld=1 inc=0", hit, vid_ld, vid_inc);
        end
        for (int i = 0; i < 12; i++) begin
            vid_sync = (i < 6);
            cycle();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL sync_after cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
            end
        end
        vid_sync = 0;
    endtask

    task automatic test_reset_mid_slot();
        bit found = 0;
        cyc_en = 1; vid_req = 0; dma_req = 1; cpu_req = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            cycle();
            found = (m_owner == 2 && m_phase == 2);
        end
        #2 xr = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (!found || grant !== 4'b0000 || xras !== 1'b1 || xcas !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_slot_reset found=%0d got g=%b ras=%b cas=%b exp g=0000 ras=1 cas=1",
                     found, grant, xras, xcas);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge c); #1;
            n_tests++;
            if (dma_ack !== 1'b0 || grant !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got ack=%b g=%b exp ack=0 g=0000", i, dma_ack, grant);
            end
        end
        @(negedge c); xr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL after_reset cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cyc_en   = ($urandom_range(0, 3) != 0);
            vid_req  = ($urandom_range(0, 7) == 0) ? !vid_req : vid_req;
            dma_req  = ($urandom_range(0, 2) == 0);
            cpu_req  = ($urandom_range(0, 1) == 0);
            vid_sync = ($urandom_range(0, 9) == 0);
            cycle();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_refresh_saturation();
        bit cur_ref = 0;
        int run = 0;
        rt_ref_done = 0;
        rt_slot_end = 1;
        for (int i = 0; i < 10 * RT_DIV; i++) begin
            @(posedge c); #1;
        end
        rt_slot_end = 0;
        #1;
        n_tests++;
        if (rt_due !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pending got due=%b exp 1", rt_due);
        end
        for (int k = 0; k < 6; k++) begin
            rt_slot_end = 1; rt_ref_done = cur_ref;
            #1;
            n_tests++;
            if (rt_due !== logic'(k < MAX)) begin
                n_fail++;
                $display("FAIL sat_drain slot=%0d got due=%b exp %b", k, rt_due, logic'(k < MAX));
            end
            if (rt_due) run++;
            cur_ref = rt_due;
            @(posedge c); #1;
        end
        rt_slot_end = 0; rt_ref_done = 0;
        n_tests++;
        if (run !== MAX) begin
            n_fail++;
            $display("FAIL sat_run got=%0d exp=%0d", run, MAX);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        test_vid_cpu();
        test_refresh();
        test_sync_collision();
        test_reset_mid_slot();
        test_random();
        test_refresh_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
